// File: rtl/rf_pkg.sv
// Shared widths and the writeback request type for the register-file write path.
package rf_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small writeback FIFO without fall-through; exposes per-slot valid/idx so the
// arbiter can report pending writers to decode.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]  entry_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [AW-1:0] off;

  // Extra pointer MSB tells a full ring apart from an empty one.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_req;
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    off         = '0;
    entry_valid = '0;
    entry_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i] = ({1'b0, off} < count);
      entry_idx[i]   = mem[i].idx;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write initiator: buffers ALU and LSU writebacks, arbitrates one
// write per cycle with a starvation guard for the LSU, and reports bypass/pending.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_idx,
  input  logic [XLEN-1:0]      a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_idx,
  input  logic [XLEN-1:0]      b_data,
  output logic                 rf_wr_en,
  output logic [REG_IDX_W-1:0] rf_wr_idx,
  output logic [XLEN-1:0]      rf_wr_data,
  input  logic [REG_IDX_W-1:0] byp_idx1,
  input  logic [REG_IDX_W-1:0] byp_idx2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [XLEN-1:0]      byp_data1,
  output logic [XLEN-1:0]      byp_data2,
  output logic                 pend1,
  output logic                 pend2
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t a_req, b_req, a_head, b_head, win_req;
  logic    a_full, a_empty, b_full, b_empty;
  logic    a_win, b_win, any_win;
  logic [SW-1:0] starve_cnt;
  logic [FIFO_DEPTH-1:0]                a_ev, b_ev;
  logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] a_eidx, b_eidx;

  assign a_ready = !a_full && !reset;
  assign b_ready = !b_full && !reset;
  assign a_req   = '{idx: a_idx, data: a_data};
  assign b_req   = '{idx: b_idx, data: b_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(a_valid && a_ready), .push_req(a_req),
    .pop(a_win), .head(a_head), .full(a_full), .empty(a_empty),
    .entry_valid(a_ev), .entry_idx(a_eidx)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(b_valid && b_ready), .push_req(b_req),
    .pop(b_win), .head(b_head), .full(b_full), .empty(b_empty),
    .entry_valid(b_ev), .entry_idx(b_eidx)
  );

  // A has priority; B takes over once it has lost STARVE_MAX times in a row.
  assign b_win   = !b_empty && (a_empty || (starve_cnt == SW'(STARVE_MAX)));
  assign a_win   = !a_empty && !b_win;
  assign any_win = a_win || b_win;
  assign win_req = b_win ? b_head : a_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_idx  <= '0;
      rf_wr_data <= '0;
    end else begin
      if (!b_empty && !b_win)
        starve_cnt <= (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      rf_wr_en <= any_win && (win_req.idx != '0);
      if (any_win && (win_req.idx != '0)) begin
        rf_wr_idx  <= win_req.idx;
        rf_wr_data <= win_req.data;
      end
    end
  end

  assign byp_hit1  = rf_wr_en && (rf_wr_idx == byp_idx1) && (byp_idx1 != '0);
  assign byp_hit2  = rf_wr_en && (rf_wr_idx == byp_idx2) && (byp_idx2 != '0);
  assign byp_data1 = byp_hit1 ? rf_wr_data : '0;
  assign byp_data2 = byp_hit2 ? rf_wr_data : '0;

  // x0 entries never make decode stall, so they are skipped here.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_ev[i] && (a_eidx[i] != '0)) begin
        if (a_eidx[i] == byp_idx1) pend1 = 1'b1;
        if (a_eidx[i] == byp_idx2) pend2 = 1'b1;
      end
      if (b_ev[i] && (b_eidx[i] != '0)) begin
        if (b_eidx[i] == byp_idx1) pend1 = 1'b1;
        if (b_eidx[i] == byp_idx2) pend2 = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (FIFO_DEPTH=2, STARVE_MAX=3).
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_idx = '0, b_idx = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_idx;
  logic [31:0] rf_wr_data;
  logic [4:0]  byp_idx1 = '0, byp_idx2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
  logic        pend1, pend2;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_data(b_data),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .byp_idx1(byp_idx1), .byp_idx2(byp_idx2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_seq [8];
  logic        a_acc, b_acc;

  initial begin
    exp_seq = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hB000_0000,
                32'hA000_0003, 32'hA000_0004, 32'hA000_0005, 32'hB000_0001};

    // Power-on reset
    tick();
    check_output("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check_output("rst_a_ready", 32'(a_ready), 32'd0);
    check_output("rst_b_ready", 32'(b_ready), 32'd0);
    check_output("rst_wr_data", rf_wr_data, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_output("post_rst_a_ready", 32'(a_ready), 32'd1);
    check_output("post_rst_b_ready", 32'(b_ready), 32'd1);

    // A only: push idx 5 / DEADBEEF, commit two edges later
    a_valid = 1'b1; a_idx = 5'd5; a_data = 32'hDEAD_BEEF; byp_idx1 = 5'd5;
    tick();
    a_valid = 1'b0;
    #1;
    check_output("a_only_pend1", 32'(pend1), 32'd1);
    check_output("a_only_no_early_wr", 32'(rf_wr_en), 32'd0);
    tick();
    check_output("a_only_wr_en", 32'(rf_wr_en), 32'd1);
    check_output("a_only_wr_idx", 32'(rf_wr_idx), 32'd5);
    check_output("a_only_wr_data", rf_wr_data, 32'hDEAD_BEEF);
    check_output("a_only_byp_hit1", 32'(byp_hit1), 32'd1);
    check_output("a_only_byp_data1", byp_data1, 32'hDEAD_BEEF);
    check_output("a_only_pend1_clear", 32'(pend1), 32'd0);
    tick();
    check_output("a_only_idle_wr_en", 32'(rf_wr_en), 32'd0);
    check_output("a_only_hold_idx", 32'(rf_wr_idx), 32'd5);
    check_output("a_only_idle_byp_hit1", 32'(byp_hit1), 32'd0);
    check_output("a_only_idle_byp_data1", byp_data1, 32'd0);

    // x0 write: popped silently, no bypass/pending
    a_valid = 1'b1; a_idx = 5'd0; a_data = 32'h0000_1234; byp_idx1 = 5'd0;
    tick();
    a_valid = 1'b0;
    #1;
    check_output("x0_pend1", 32'(pend1), 32'd0);
    tick();
    check_output("x0_wr_en", 32'(rf_wr_en), 32'd0);
    check_output("x0_hold_data", rf_wr_data, 32'hDEAD_BEEF);
    check_output("x0_byp_hit1", 32'(byp_hit1), 32'd0);
    tick();
    check_output("x0_drained_a_ready", 32'(a_ready), 32'd1);

    // Starvation + B backpressure: both sources push continuously
    a_idx = 5'd3; b_idx = 5'd4; byp_idx1 = 5'd3;
    a_data = 32'hA000_0000; b_data = 32'hB000_0000;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      tick();
      if (a_acc) a_data = a_data + 32'd1;
      if (b_acc) b_data = b_data + 32'd1;
      #1;
      if (k >= 1) begin
        check_output($sformatf("starve_wr_en_%0d", k), 32'(rf_wr_en), 32'd1);
        check_output($sformatf("starve_wr_data_%0d", k), rf_wr_data, exp_seq[k-1]);
      end
      if (k == 1) check_output("bp_b_ready_full", 32'(b_ready), 32'd0);
      if (k == 4) check_output("bp_b_ready_after_pop", 32'(b_ready), 32'd1);
    end
    check_output("pre_rst_a_full", 32'(a_ready), 32'd0);
    check_output("pre_rst_pend1", 32'(pend1), 32'd1);

    // Reset mid-operation: immediate clear, no stale writes afterwards
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_output("midrst_wr_en", 32'(rf_wr_en), 32'd0);
    check_output("midrst_a_ready", 32'(a_ready), 32'd0);
    check_output("midrst_b_ready", 32'(b_ready), 32'd0);
    check_output("midrst_pend1", 32'(pend1), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_output("midrst_post_a_ready", 32'(a_ready), 32'd1);
    check_output("midrst_post_b_ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("no_stale_wr_%0d", k), 32'(rf_wr_en), 32'd0);
    end

    // Pending on B: idx 7 visible as pend2 until popped, then bypassed
    b_valid = 1'b1; b_idx = 5'd7; b_data = 32'h0000_0077; byp_idx2 = 5'd7;
    tick();
    b_valid = 1'b0;
    #1;
    check_output("pend2_held", 32'(pend2), 32'd1);
    check_output("pend2_no_hit_yet", 32'(byp_hit2), 32'd0);
    tick();
    check_output("pend2_cleared", 32'(pend2), 32'd0);
    check_output("byp_hit2_commit", 32'(byp_hit2), 32'd1);
    check_output("byp_data2_commit", byp_data2, 32'h0000_0077);
    check_output("b_wr_idx", 32'(rf_wr_idx), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-side initiator for the 32x32 register file. It collects writeback results from two producers, the ALU (source A) and the load/store unit (source B), through valid/ready handshakes and buffers each in a small FIFO. It arbitrates to at most one register-file write per cycle and drives the file's wr_en/wr_idx/wr_data. It also exports bypass and pending-hazard information for the decode-stage read ports.

Parameters:
FIFO_DEPTH, 2, entries per source FIFO (power of two, at least 2)
STARVE_MAX, 3, consecutive lost arbitrations by B before B is forced to win

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
a_valid  in  1  ALU result valid
a_ready  out  1  ALU FIFO can accept
a_idx  in  5  ALU destination register
a_data  in  32  ALU result
b_valid  in  1  LSU result valid
b_ready  out  1  LSU FIFO can accept
b_idx  in  5  LSU destination register
b_data  in  32  LSU load data
rf_wr_en  out  1  register-file write enable (registered)
rf_wr_idx  out  5  register-file write index (registered)
rf_wr_data  out  32  register-file write data (registered)
byp_idx1, byp_idx2  in  5 each  decode-stage read indices
byp_hit1, byp_hit2  out  1 each  forward from rf_wr_data this cycle
byp_data1, byp_data2  out  32 each  forwarded data
pend1, pend2  out  1 each  index is held in any FIFO entry (decode must stall)

Behaviour:
- Reset (asynchronous assert) clears:
  - FIFOs to empty and the starve counter to 0
  - rf_wr_en=0, rf_wr_idx=0, rf_wr_data=0
  - byp_hit*=0, byp_data*=0, pend*=0
  - a_ready and b_ready are 0 while reset is asserted and 1 on the first cycle after deassert.
  - Any in-flight entries are discarded; no write is issued for them.
- Handshake:
  - A push occurs when x_valid & x_ready at posedge.
  - x_ready = !full_x. It has no combinational dependence on x_valid or on pops.
  - When full, a same-cycle pop does not make room; ready stays 0 that cycle.
  - Producers hold valid/idx/data stable until accepted.
- Arbitration each cycle over the two FIFO heads:
  - If only one head is non-empty, that head wins.
  - If both are non-empty, A wins unless starve_cnt == STARVE_MAX, in which case B wins.
  - starve_cnt increments when B is non-empty and loses. It clears when B wins or B is empty. It saturates at STARVE_MAX.
- Commit:
  - The winner pops and its entry registers onto rf_wr_* at the next posedge (1-cycle latency).
  - An entry pushed in cycle N is visible on rf_wr_* no earlier than cycle N+2 (there is no FIFO fall-through).
  - rf_wr_en=0 in any cycle with no pop.
  - rf_wr_idx/rf_wr_data hold their last value when rf_wr_en=0.
- x0 handling:
  - Entries with idx 0 are accepted and popped normally, but produce rf_wr_en=0.
  - They never assert byp_hit or pend.
- Ordering:
  - FIFO order is preserved within a source.
  - No ordering is guaranteed across sources. Decode uses pend* to avoid issuing conflicting writers.
- Bypass (combinational from registered state):
  - byp_hitK = rf_wr_en & (rf_wr_idx == byp_idxK) & (byp_idxK != 0).
  - byp_dataK = rf_wr_data when hit, else 0.
- Pending:
  - pendK = OR over all valid entries in both FIFOs of (entry.idx == byp_idxK), with byp_idxK != 0.
  - An entry popped this cycle still counts as pending this cycle.
- Pointers:
  - Width is log2(FIFO_DEPTH)+1; wrap-around uses the MSB to distinguish full from empty.

Decomposition:
- Package rf_pkg:
  - XLEN=32, REG_IDX_W=5, NUM_REGS=32
  - typedef wb_req_t {idx[4:0], data[31:0]}
- Sub-module wb_fifo:
  - Parameterized depth, holds wb_req_t, with push/pop/full/empty.
  - Exposes an entry-valid vector and an entry-idx array for pending detection.
  - Instantiated twice (one per source).

Test Plan:
- Reset mid-operation: both FIFOs full, assert reset -> rf_wr_en=0 at once; after deassert a_ready=b_ready=1 and no stale writes ever appear.
- A only: push (idx 5, 0xDEADBEEF) at cycle N -> rf_wr_en=1, idx 5, data 0xDEADBEEF at cycle N+2; byp_idx1=5 gives byp_hit1=1 with 0xDEADBEEF in that cycle.
- Starvation: A and B valid every cycle -> A wins 3 consecutive cycles, B wins the 4th, and the pattern repeats.
- Backpressure: FIFO_DEPTH=2, B pushes 3 entries while A saturates arbitration -> b_ready=0 after 2 accepts; the 3rd is accepted only after B's first pop; B's FIFO order is preserved.
- x0 write: A pushes (idx 0, 0x1234) -> popped, rf_wr_en stays 0; byp_idx1=0 gives byp_hit1=0 and pend1=0.
- Pending: B holds idx 7 in its FIFO, byp_idx2=7 -> pend2=1 until the cycle after its pop; byp_hit2=1 during its commit cycle.
